// File: rtl/parser_pkg.sv
// Shared ASCII constants, parser state encoding and byte classification.
package parser_pkg;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_SP = 8'h20;

  typedef enum logic {
    IDLE,
    ACCUM
  } state_e;

  typedef enum logic [1:0] {
    BC_DIGIT,
    BC_TERM,
    BC_INVALID
  } byte_class_e;

  // Sort a received byte into digit / terminator / garbage.
  function automatic byte_class_e classify(input logic [7:0] b);
    if (b >= ASCII_0 && b <= ASCII_9) begin
      return BC_DIGIT;
    end else if (b == ASCII_CR || b == ASCII_LF || b == ASCII_SP) begin
      return BC_TERM;
    end else begin
      return BC_INVALID;
    end
  endfunction

endpackage

// File: rtl/cmd_parser.sv
// ASCII decimal number parser: accumulates digit bytes into a binary value and
// emits it on digit-count limit, terminator, or optional idle timeout.
module cmd_parser
  import parser_pkg::*;
#(
  parameter int unsigned MAX_DIGITS     = 3,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [15:0] number_out,
  output logic        number_valid
);

  localparam int unsigned CNT_W  = $clog2(MAX_DIGITS + 1);
  localparam int unsigned IDLE_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_e            state, state_d;
  logic [15:0]       acc, acc_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [IDLE_W-1:0] idle_cnt, idle_d;
  logic [15:0]       number_d;
  logic              valid_d;
  logic [15:0]       new_val;

  // Accumulator with the current byte appended as the next decimal digit.
  assign new_val = 16'(acc * 16'd10) + 16'(rx_data - ASCII_0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      acc          <= '0;
      cnt          <= '0;
      idle_cnt     <= '0;
      number_out   <= '0;
      number_valid <= 1'b0;
    end else begin
      state        <= state_d;
      acc          <= acc_d;
      cnt          <= cnt_d;
      idle_cnt     <= idle_d;
      number_out   <= number_d;
      number_valid <= valid_d;
    end
  end

  always_comb begin
    state_d  = state;
    acc_d    = acc;
    cnt_d    = cnt;
    idle_d   = idle_cnt;
    number_d = number_out;
    valid_d  = 1'b0;

    if (rx_valid) begin
      // Any byte restarts the idle window, so it wins over a same-cycle timeout.
      idle_d = '0;
      unique case (classify(rx_data))
        BC_DIGIT: begin
          if (cnt == CNT_W'(MAX_DIGITS - 1)) begin
            number_d = new_val;
            valid_d  = 1'b1;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = IDLE;
          end else begin
            acc_d   = new_val;
            cnt_d   = cnt + CNT_W'(1);
            state_d = ACCUM;
          end
        end
        BC_TERM: begin
          if (state == ACCUM) begin
            number_d = acc;
            valid_d  = 1'b1;
          end
          acc_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
        default: begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end else if (TIMEOUT_CYCLES > 0 && state == ACCUM) begin
      if (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
        number_d = acc;
        valid_d  = 1'b1;
        acc_d    = '0;
        cnt_d    = '0;
        idle_d   = '0;
        state_d  = IDLE;
      end else begin
        idle_d = idle_cnt + IDLE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cmd_parser.sv
// Directed self-checking bench for cmd_parser (default config and a timeout config).
module tb_cmd_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [15:0] number_out;
  logic        number_valid;
  logic [7:0]  rx_data_t = 8'h00;
  logic        rx_valid_t = 1'b0;
  logic [15:0] number_out_t;
  logic        number_valid_t;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cmd_parser dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .number_out   (number_out),
    .number_valid (number_valid)
  );

  cmd_parser #(.MAX_DIGITS(3), .TIMEOUT_CYCLES(5)) dut_to (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data_t),
    .rx_valid     (rx_valid_t),
    .number_out   (number_out_t),
    .number_valid (number_valid_t)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive a byte (or idle) at negedge, check both outputs after posedge.
  task automatic step(input bit t, input logic v, input logic [7:0] d,
                      input logic ev, input logic [15:0] en, input string tag);
    @(negedge clk);
    if (t) begin
      rx_valid_t = v; rx_data_t = d;
    end else begin
      rx_valid = v; rx_data = d;
    end
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, {15'd0, t ? number_valid_t : number_valid}, {15'd0, ev});
    chk({tag, ".num"}, t ? number_out_t : number_out, en);
  endtask

  initial begin
    // Reset clears outputs without a clock edge.
    #1;
    chk("reset.valid", {15'd0, number_valid}, 16'd0);
    chk("reset.num", number_out, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    // "123" with two idle cycles between strobes
    step(0, 1, 8'h31, 0, 0, "s123_1");
    step(0, 0, 8'h00, 0, 0, "s123_g1");
    step(0, 0, 8'h00, 0, 0, "s123_g2");
    step(0, 1, 8'h32, 0, 0, "s123_2");
    step(0, 0, 8'h00, 0, 0, "s123_g3");
    step(0, 0, 8'h00, 0, 0, "s123_g4");
    step(0, 1, 8'h33, 1, 123, "s123_3");
    step(0, 0, 8'h00, 0, 123, "s123_hold");

    // "456"
    step(0, 1, 8'h34, 0, 123, "s456_4");
    step(0, 1, 8'h35, 0, 123, "s456_5");
    step(0, 1, 8'h36, 1, 456, "s456_6");
    step(0, 0, 8'h00, 0, 456, "s456_hold");

    // 'A' then "12" CR
    step(0, 1, 8'h41, 0, 456, "garbA");
    step(0, 1, 8'h31, 0, 456, "s12_1");
    step(0, 1, 8'h32, 0, 456, "s12_2");
    step(0, 1, 8'h0D, 1, 12, "s12_cr");
    step(0, 0, 8'h00, 0, 12, "s12_hold");

    // "9" 'x' "87" LF
    step(0, 1, 8'h39, 0, 12, "s9");
    step(0, 1, 8'h78, 0, 12, "garbx");
    step(0, 1, 8'h38, 0, 12, "s87_8");
    step(0, 1, 8'h37, 0, 12, "s87_7");
    step(0, 1, 8'h0A, 1, 87, "s87_lf");

    // Terminator while idle is ignored
    step(0, 1, 8'h20, 0, 87, "sp_idle");

    // "789123" back to back
    step(0, 1, 8'h37, 0, 87, "b2b_7");
    step(0, 1, 8'h38, 0, 87, "b2b_8");
    step(0, 1, 8'h39, 1, 789, "b2b_9");
    step(0, 1, 8'h31, 0, 789, "b2b_1");
    step(0, 1, 8'h32, 0, 789, "b2b_2");
    step(0, 1, 8'h33, 1, 123, "b2b_3");

    // Largest value, then leading zeros
    step(0, 1, 8'h39, 0, 123, "max_9a");
    step(0, 1, 8'h39, 0, 123, "max_9b");
    step(0, 1, 8'h39, 1, 999, "max_9c");
    step(0, 1, 8'h30, 0, 999, "lz_0a");
    step(0, 1, 8'h30, 0, 999, "lz_0b");
    step(0, 1, 8'h37, 1, 7, "lz_7");

    // Async reset mid-number drops the partial value
    step(0, 1, 8'h35, 0, 7, "rst_5");
    @(negedge clk);
    rx_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_mid.num", number_out, 16'd0);
    chk("rst_mid.valid", {15'd0, number_valid}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    step(0, 1, 8'h33, 0, 0, "rst_3");
    step(0, 1, 8'h0D, 1, 3, "rst_cr");
    step(0, 0, 8'h00, 0, 3, "rst_hold");

    // Timeout configuration: fresh reset
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    step(1, 1, 8'h34, 0, 0, "to_4");
    step(1, 1, 8'h32, 0, 0, "to_2");
    for (int i = 0; i < 4; i++) step(1, 0, 8'h00, 0, 0, "to_wait");
    step(1, 0, 8'h00, 1, 42, "to_fire");
    step(1, 0, 8'h00, 0, 42, "to_after");

    // Byte arriving on the would-be timeout cycle wins
    step(1, 1, 8'h31, 0, 42, "tw_1");
    for (int i = 0; i < 4; i++) step(1, 0, 8'h00, 0, 42, "tw_wait");
    step(1, 1, 8'h32, 0, 42, "tw_2");
    for (int i = 0; i < 4; i++) step(1, 0, 8'h00, 0, 42, "tw_wait2");
    step(1, 0, 8'h00, 1, 12, "tw_fire");

    // "4", reset, "56" CR
    step(1, 1, 8'h34, 0, 12, "tr_4");
    @(negedge clk);
    rx_valid_t = 1'b0;
    rst = 1'b1;
    #1;
    chk("tr_rst.num", number_out_t, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    step(1, 1, 8'h35, 0, 0, "tr_5");
    step(1, 1, 8'h36, 0, 0, "tr_6");
    step(1, 1, 8'h0D, 1, 56, "tr_cr");
    step(1, 0, 8'h00, 0, 56, "tr_hold");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cmd_parser.md
# cmd_parser

ASCII decimal number parser between the UART receiver and the command/control logic. It consumes one received byte per `rx_valid` strobe and accumulates decimal digits into a binary value. It presents the completed number on `number_out` with a one-cycle `number_valid` pulse, either when the digit limit is reached or when a terminator arrives. Non-digit garbage aborts the number in progress without producing output.

## Interface
- `MAX_DIGITS`, default 3: digits per number; completion is automatic at this count. Legal range 1..4, so the result always fits 16 bits.
- `TIMEOUT_CYCLES`, default 0: idle cycles after the last digit before a partial number is emitted. 0 disables the timeout. Counter width is derived from the value.
- `clk` input, 1 bit: single clock; all logic on the rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `rx_data` input, 8 bits: received ASCII byte, valid only while `rx_valid` is high.
- `rx_valid` input, 1 bit: byte strobe. Each high cycle is one byte; consecutive high cycles are distinct bytes.
- `number_out` output, 16 bits: last completed number, unsigned binary. Held until the next completion.
- `number_valid` output, 1 bit: one-cycle pulse coinciding with each update of `number_out`.

## Operation
- Byte classes:
  - Digit: 0x30–0x39.
  - Terminator: CR 0x0D, LF 0x0A, space 0x20.
  - Everything else is invalid.
- Internal state: accumulator `acc` (16 bits), digit count `cnt` (0..MAX_DIGITS), idle counter.
- States:
  - IDLE: `cnt` = 0.
  - ACCUM: 0 < `cnt` < MAX_DIGITS.
- Digit, with `new = acc*10 + (rx_data - 0x30)`:
  - If `cnt+1 == MAX_DIGITS`: emit `new`, clear `acc` and `cnt`, go to IDLE.
  - Otherwise: `acc <= new`, `cnt <= cnt+1`, go to ACCUM.
- Terminator:
  - In ACCUM: emit `acc`, clear, go to IDLE.
  - In IDLE: ignored, no pulse.
- Invalid byte: clear `acc` and `cnt`, go to IDLE. No pulse. `number_out` is unchanged.
- Timeout (only when `TIMEOUT_CYCLES` > 0): in ACCUM, the idle counter increments on each cycle with `rx_valid` low and resets on any `rx_valid`. Reaching `TIMEOUT_CYCLES` emits `acc` and returns to IDLE.
- Emit means `number_out <= value`, `number_valid <= 1` for exactly one cycle.
- Leading zeros count as digits: "007" emits 7.
- Arithmetic is unsigned. `acc*10` is computed in 16 bits; with `MAX_DIGITS` ≤ 4 it cannot overflow.

## Timing
- Reset values: `number_out` = 0, `number_valid` = 0, `acc` = 0, `cnt` = 0, idle counter = 0, state IDLE. Reset takes effect immediately, mid-number included, and the partial value is lost.
- Latency: a byte sampled at edge N that completes a number updates `number_out` and raises `number_valid` at the same edge N. Both are visible in the cycle after edge N. `number_valid` drops at edge N+1 unless edge N+1 completes another number.
- Full throughput: `rx_valid` may be high on every cycle. Back-to-back completions produce `number_valid` high on consecutive cycles, each with its own value.
- A timeout and an arriving byte in the same cycle: the byte wins and the idle counter resets.
- No backpressure; every strobed byte is consumed.

## Structure
- Shared package `parser_pkg`: ASCII constants (`ASCII_0`, `ASCII_9`, `ASCII_CR`, `ASCII_LF`, `ASCII_SP`) and a state enum (IDLE, ACCUM).
- Single module. Byte classification is a small combinational function in the package; no sub-module.

## Test plan
- Reset: assert `rst`. `number_out` = 0 and `number_valid` = 0 immediately, without waiting for a clock edge.
- "123" as three strobes, two idle cycles apart: exactly one `number_valid` pulse, `number_out` = 123, pulse in the cycle after the '3' edge.
- "456" sent after "123": one pulse, `number_out` = 456. 123 is held between the two numbers.
- 'A' (0x41) alone, then "12" + CR: no pulse for 'A'; `number_out` stays 456; then one pulse with 12.
- "9", 'x', "87", LF: no pulse after 'x', one pulse with 87.
- "789123" with `rx_valid` high for 6 consecutive cycles: pulses on two consecutive-group edges, values 789 then 123.
- `TIMEOUT_CYCLES` = 5, "42" then silence: pulse with 42 exactly 5 idle cycles after the '2'. Also apply `rst` mid-number ("4", `rst`, "56" + CR): emits 56.
